// File: rtl/fetch_stage.sv
// fetch_stage: PC register and instruction-fetch front end.
// Owns the architectural PC and runs the req/ack handshake with instruction
// memory. Fetched {pc, instr} pairs go into a 2-entry queue whose head drives
// decode. A flush drops the queue and any fetch still in flight. When a fetch
// is abandoned by a flush but not yet acked, the request is held until memory
// acks it, and that data is thrown away.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] nextpc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, FULL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] e0_pc_q, e0_pc_d, e0_instr_q, e0_instr_d;
    logic [31:0] e1_pc_q, e1_pc_d, e1_instr_q, e1_instr_d;
    logic [1:0]  cnt_q, cnt_d, cnt_mid;
    logic        pop, push;
    logic [31:0] fpc;

    // The low two bits of the redirect target are not used: targets are words.
    logic unused_flush_lsb;
    assign unused_flush_lsb = ^flush_pc[1:0];

    assign fpc       = {flush_pc[31:2], 2'b00};
    assign pc        = pc_q;
    assign imem_req  = imem_req_q;
    assign imem_addr = req_addr_q;
    assign if_valid  = (cnt_q != 2'd0);
    assign if_pc     = e0_pc_q;
    assign if_instr  = e0_instr_q;

    // Next-state logic for the queue, the PC and the request FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        e0_pc_d    = e0_pc_q;
        e0_instr_d = e0_instr_q;
        e1_pc_d    = e1_pc_q;
        e1_instr_d = e1_instr_q;

        pop  = if_valid & id_ready;
        // Data from memory is kept only for a live fetch that no flush has cut off.
        push = (state_q == REQ) & imem_ack & ~flush;

        // The queue is a 2-deep shift FIFO. Slot 0 is always the head.
        cnt_mid = cnt_q - {1'b0, pop};
        if (pop) begin
            e0_pc_d    = e1_pc_q;
            e0_instr_d = e1_instr_q;
        end
        if (push) begin
            if (cnt_mid == 2'd0) begin
                e0_pc_d    = pc_q;
                e0_instr_d = imem_rdata;
            end else begin
                e1_pc_d    = pc_q;
                e1_instr_d = imem_rdata;
            end
        end
        cnt_d = cnt_mid + {1'b0, push};
        if (flush) cnt_d = 2'd0;

        unique case (state_q)
            IDLE: begin
                state_d    = REQ;
                req_addr_d = pc_q;
                if (flush) begin
                    pc_d       = fpc;
                    req_addr_d = fpc;
                end
            end
            REQ: begin
                if (flush) begin
                    pc_d = fpc;
                    // Without an ack the address stays put, so hold it in DRAIN.
                    if (imem_ack) req_addr_d = fpc;
                    else          state_d    = DRAIN;
                end else if (imem_ack) begin
                    pc_d = nextpc;
                    if (cnt_d == 2'd2) state_d    = FULL;
                    else               req_addr_d = nextpc;
                end
            end
            DRAIN: begin
                if (flush) pc_d = fpc;
                if (imem_ack) begin
                    state_d    = REQ;
                    req_addr_d = flush ? fpc : pc_q;
                end
            end
            FULL: begin
                if (flush) begin
                    pc_d       = fpc;
                    req_addr_d = fpc;
                    state_d    = REQ;
                end else if (pop) begin
                    state_d    = REQ;
                    req_addr_d = pc_q;
                end
            end
            default: state_d = IDLE;
        endcase

        imem_req_d = (state_d == REQ) || (state_d == DRAIN);
    end

    // State registers. Reset clears the request at once, so a late ack is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= 32'h0;
            imem_req_q <= 1'b0;
            cnt_q      <= 2'd0;
            e0_pc_q    <= 32'h0;
            e0_instr_q <= 32'h0;
            e1_pc_q    <= 32'h0;
            e1_instr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            imem_req_q <= imem_req_d;
            cnt_q      <= cnt_d;
            e0_pc_q    <= e0_pc_d;
            e0_instr_q <= e0_instr_d;
            e1_pc_q    <= e1_pc_d;
            e1_instr_q <= e1_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. A memory model and next-PC model sit around the DUT.
// A scoreboard records each fetch that memory completes and checks the order
// in which decode receives them. Directed steps check the cycle-level behaviour.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, nextpc, flush_pc, imem_addr, imem_rdata, if_pc, if_instr;
    logic        flush, imem_req, imem_ack, if_valid, id_ready;

    logic        ack_on, np_over;
    logic [31:0] np_val;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t sb[$];
    logic drain_exp = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    assign imem_rdata = mem(imem_addr);
    assign imem_ack   = ack_on & imem_req;
    assign nextpc     = np_over ? np_val : pc + 32'd4;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .nextpc(nextpc), .flush(flush),
        .flush_pc(flush_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Scoreboard. It samples after the directed steps have driven inputs for the
    // next rising edge. It compares each pop, then records each completed fetch.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            sb.delete();
            drain_exp = 1'b0;
        end else if (flush) begin
            sb.delete();
            drain_exp = imem_req & ~imem_ack;
        end else begin
            if (if_valid && id_ready) begin
                if (sb.size() == 0) begin
                    timeout("sb_stale_pop");
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    check("sb_if_pc", if_pc, e.pc);
                    check("sb_if_instr", if_instr, e.instr);
                end
            end
            if (imem_req && imem_ack) begin
                if (drain_exp) drain_exp = 1'b0;
                else sb.push_back({imem_addr, mem(imem_addr)});
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0; flush = 1'b0; flush_pc = 32'h0; id_ready = 1'b0;
        ack_on = 1'b0; np_over = 1'b0; np_val = 32'h0;
        #1;
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);

        // Stream with an always-ack memory and nextpc = pc+4.
        @(negedge clk); rst_n = 1'b1; ack_on = 1'b1; id_ready = 1'b1;
        @(negedge clk);
        check("s_req", {31'h0, imem_req}, 32'h1);
        check("s_addr0", imem_addr, 32'h0);
        check("s_valid0", {31'h0, if_valid}, 32'h0);
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            check("s_addr", imem_addr, 32'(4 * k));
            check("s_valid", {31'h0, if_valid}, 32'h1);
            check("s_if_pc", if_pc, 32'(4 * (k - 1)));
            @(negedge clk);
        end

        // Fill the queue with decode stalled, then release it.
        rst_n = 1'b0; id_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); check("f_addr0", imem_addr, 32'h0);
        @(negedge clk); check("f_addr4", imem_addr, 32'h4);
        @(negedge clk);
        check("f_full_req", {31'h0, imem_req}, 32'h0);
        check("f_full_valid", {31'h0, if_valid}, 32'h1);
        check("f_full_pc", pc, 32'h8);
        @(negedge clk);
        check("f_hold_req", {31'h0, imem_req}, 32'h0);
        check("f_hold_if_pc", if_pc, 32'h0);
        id_ready = 1'b1;
        @(negedge clk);
        check("f_resume_req", {31'h0, imem_req}, 32'h1);
        check("f_resume_addr", imem_addr, 32'h8);
        check("f_second", if_pc, 32'h4);

        // Flush while the request to 0x10 is waiting.
        guard = 0;
        while (imem_addr != 32'h10 && guard < 20) begin @(negedge clk); guard++; end
        if (guard >= 20) timeout("wait_addr_10");
        ack_on = 1'b0; flush = 1'b1; flush_pc = 32'h8000_0080;
        @(negedge clk); flush = 1'b0;
        check("d_pc", pc, 32'h8000_0080);
        for (int k = 0; k < 3; k++) begin
            check("d_req", {31'h0, imem_req}, 32'h1);
            check("d_addr_hold", imem_addr, 32'h10);
            check("d_empty", {31'h0, if_valid}, 32'h0);
            if (k == 2) ack_on = 1'b1;
            @(negedge clk);
        end
        check("d_new_addr", imem_addr, 32'h8000_0080);
        check("d_drop", {31'h0, if_valid}, 32'h0);
        @(negedge clk);
        check("d_first", if_pc, 32'h8000_0080);
        check("d_next_addr", imem_addr, 32'h8000_0084);

        // Flush with a pop on a full queue; also test flush_pc alignment.
        id_ready = 1'b0;
        guard = 0;
        while (imem_req && guard < 20) begin @(negedge clk); guard++; end
        if (guard >= 20) timeout("wait_full");
        check("x_full_valid", {31'h0, if_valid}, 32'h1);
        flush = 1'b1; flush_pc = 32'h0040_0007; id_ready = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("x_valid", {31'h0, if_valid}, 32'h0);
        check("x_req", {31'h0, imem_req}, 32'h1);
        check("x_align", imem_addr, 32'h0040_0004);
        np_over = 1'b1; np_val = 32'h1000;
        @(negedge clk); np_over = 1'b0;
        check("n_addr", imem_addr, 32'h1000);
        check("n_if_pc", if_pc, 32'h0040_0004);
        @(negedge clk);
        check("n_addr2", imem_addr, 32'h1004);

        // Flush coincident with an ack and a pop while requesting.
        flush = 1'b1; flush_pc = 32'h2000;
        @(negedge clk); flush = 1'b0;
        check("a_valid", {31'h0, if_valid}, 32'h0);
        check("a_addr", imem_addr, 32'h2000);
        @(negedge clk);
        check("a_if_pc", if_pc, 32'h2000);
        check("a_if_instr", if_instr, mem(32'h2000));

        // Assert reset while a request is outstanding.
        ack_on = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("r_req", {31'h0, imem_req}, 32'h0);
        check("r_pc", pc, 32'h0);
        check("r_valid", {31'h0, if_valid}, 32'h0);
        ack_on = 1'b1;
        @(negedge clk); @(negedge clk);
        check("r_req_held", {31'h0, imem_req}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("r_restart", imem_addr, 32'h0);
        check("r_restart_req", {31'h0, imem_req}, 32'h1);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
